// File: rtl/seq_mult_32.sv
// Radix-2 shift-add 32x32 unsigned multiplier, one multiplier bit per cycle.
// Optional early termination when SEQ_MULT_EARLY_TERM_EN is defined.
module seq_mult_32 #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);

    typedef enum logic {
        IDLE,
        CALC
    } state_t;

    state_t             state_q, state_d;
    logic [2*WIDTH-1:0] p_q, p_d;
    logic [WIDTH-1:0]   m_q, m_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    // Adder stage: A=P[63:32], B=M, carry-in tied low
    logic [WIDTH-1:0]   sum;
    logic               co;
    logic [2*WIDTH-1:0] step_p;
    logic               last;
    logic               finish;

    assign {co, sum} = {1'b0, p_q[2*WIDTH-1:WIDTH]} + {1'b0, m_q};
    assign last      = (cnt_q == CNT_W'(WIDTH-1));

    always_comb begin
        step_p = {1'b0, p_q[2*WIDTH-1:WIDTH], p_q[WIDTH-1:1]};
        if (p_q[0]) begin
            step_p = {co, sum, p_q[WIDTH-1:1]};
        end
    end

`ifdef SEQ_MULT_EARLY_TERM_EN
    logic [WIDTH-1:0] rem_mask;
    logic             rem_zero;
    logic [CNT_W-1:0] sh_amt;

    // Bits P[31-k:0] are the multiplier bits not yet consumed
    assign rem_mask = {WIDTH{1'b1}} >> cnt_q;
    assign rem_zero = ((p_q[WIDTH-1:0] & rem_mask) == '0);
    assign sh_amt   = CNT_W'(WIDTH) - cnt_q;
    assign finish   = rem_zero | last;
`else
    assign finish   = last;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            p_q     <= '0;
            m_q     <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            p_q     <= p_d;
            m_q     <= m_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        p_d     = p_q;
        m_d     = m_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    m_d     = a;
                    p_d     = {{WIDTH{1'b0}}, b};
                    cnt_d   = '0;
                    state_d = CALC;
                    busy_d  = 1'b1;
                end
            end
            CALC: begin
                cnt_d = cnt_q + 1'b1;
`ifdef SEQ_MULT_EARLY_TERM_EN
                p_d   = rem_zero ? (p_q >> sh_amt) : step_p;
`else
                p_d   = step_p;
`endif
                if (finish) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign product = p_q;

endmodule

// File: doc/seq_mult_32.md
Name: seq_mult_32

Overview:
- Iterative radix-2 shift-add unsigned multiplier for the ALU datapath: 32x32 -> 64-bit product.
- Sits directly upstream of the team's 32-bit carry-lookahead adder (CLA_Add_32bit) and drives it every iteration, with CI_0 tied to 0.
- Consumes the adder's S and CO to build the product one multiplier bit per cycle.
- Start/busy/done handshake to the ALU control.

Parameters:
- WIDTH, 32, operand width; 32 is the only legal value because the adder is fixed-width.
- CNT_W, 6, iteration counter width; must hold 0..WIDTH.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request; sampled only when busy=0.
- a  input  32  multiplicand; captured on accept.
- b  input  32  multiplier; captured on accept.
- busy  output  1  high while an operation is in progress.
- done  output  1  one-cycle pulse when the product is valid.
- product  output  64  result; held stable until the next accept.

Behaviour:
- Reset (async, rst_n=0): state=IDLE, busy=0, done=0, product=0, count=0, multiplicand reg=0. Reset mid-operation aborts immediately; no done pulse follows.
- State storage:
  - P[63:0] is the product/multiplier shift register; product is driven from P.
  - M[31:0] holds the multiplicand.
  - count[CNT_W-1:0] is the iteration counter.
- States: IDLE, CALC.
- IDLE:
  - done is deasserted one cycle after it pulses.
  - start=1 on an edge is the accept: M<=a, P<={32'b0,b}, count<=0, state<=CALC, busy<=1.
- CALC, each edge:
  - Adder inputs: A=P[63:32], B=M, CI_0=0.
  - If P[0]=1: P<={CO, S, P[31:1]}.
  - If P[0]=0: P<={1'b0, P[63:32], P[31:1]}; the adder result is ignored.
  - count<=count+1.
- Finish: on the edge where count==31 (the 32nd iteration), state<=IDLE, busy<=0, done<=1.
- Latency: done is high in the cycle following the 32nd edge after the accept edge. Throughput is one op per 33 cycles; back-to-back start is accepted in the done cycle.
- start while busy=1 is ignored. a and b may change freely after accept.
- Arithmetic:
  - Unsigned only; the 33-bit {CO,S} never overflows the 64-bit P.
  - product = a*b exactly.
  - Edge values: 0xFFFFFFFF*0xFFFFFFFF = 0xFFFFFFFE00000001.
- product holds its value through IDLE until the next accept. It shows intermediate values during CALC and is only valid when done=1 or afterwards in IDLE.

Optional Feature:
- Macro: SEQ_MULT_EARLY_TERM_EN
- Defined:
  - In a CALC cycle with count=k, if the unprocessed multiplier bits P[31-k:0] are all zero, that edge performs P<=P>>(32-k) instead of an add step.
  - The same edge finishes: state<=IDLE, busy<=0, done<=1.
  - For b=0, done fires after 1 CALC edge. Otherwise, with m = the index of b's highest set bit, done fires after min(32, m+2) CALC edges.
  - Results are identical to the non-early-termination build.
- Undefined: fixed 32-iteration latency for every operand; no early-termination comparator or shifter is present.

Test Plan:
- Reset mid-op: start a=5,b=7, assert rst_n=0 at iteration 10. Required: busy=0, done=0, product=0 immediately. No done after release.
- Basic: a=3, b=5, start one cycle. Required: busy=1 for 32 cycles; done pulses once, 32 edges after accept; product=0x000000000000000F.
- Max operands: a=b=0xFFFFFFFF. Required: product=0xFFFFFFFE00000001, exercising adder CO on every iteration.
- Busy protection and back-to-back:
  - Start a=0x10000, b=0x10000; pulse start with a=1,b=1 mid-op. Required: ignored, product=0x0000000100000000.
  - Assert start (a=2,b=9) in the done cycle. Required: accepted, next product=0x12.
- Zero and one: a=0xDEADBEEF,b=0 gives 0; a=0xDEADBEEF,b=1 gives 0x00000000DEADBEEF. Latency is 32 without the macro.
- With SEQ_MULT_EARLY_TERM_EN:
  - b=0: done after 1 CALC edge.
  - b=1: done after 2 edges, product=0x00000000DEADBEEF.
  - b=0x80000000: done after 32 edges, product=0x6F56DF7780000000.
